sram_port_initiator: RTL and testbench



---
 rtl/sram_port_initiator.sv | 139 +++++++++++++
 tb/tb_sram_port_initiator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_initiator.sv
// sram_port_initiator
//
// Request-side initiator for one masked rw port of an Sram2rwWrapper-style
// SRAM. Each accepted request becomes a single-cycle SRAM transaction. Read
// data comes back one cycle after the read enable and is captured into a
// small response FIFO. Credits are reserved at read admission, so FIFO space
// always exists for read data that is still in flight. Response backpressure
// therefore stalls new requests and never drops data.
//
// Ports:
//   clock, resetN          sole clock; synchronous active-low reset
//   req_valid/req_ready    request handshake (ready depends on state only)
//   req_write              1 = write, 0 = read
//   req_addr/mask/dataIn   word address, byte-lane enables, write data
//   resp_valid/resp_ready  read response handshake
//   resp_dataOut           read data (FIFO head register)
//   mem_*                  combinational pass-through to the SRAM rw port
//   mem_dataOut            SRAM read data, valid the cycle after a read enable
module sram_port_initiator #(
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_UNIT  = 8,
  parameter int RESP_DEPTH = 4,
  localparam int MASK_WIDTH = DATA_WIDTH / MASK_UNIT
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [MASK_WIDTH-1:0] req_mask,
  input  logic [DATA_WIDTH-1:0] req_dataIn,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_dataOut,
  output logic                  mem_enable,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [MASK_WIDTH-1:0] mem_mask,
  output logic [DATA_WIDTH-1:0] mem_dataIn,
  input  logic [DATA_WIDTH-1:0] mem_dataOut
);

  localparam int PTR_W  = $clog2(RESP_DEPTH);
  localparam int CRED_W = $clog2(RESP_DEPTH + 1);

  logic [CRED_W-1:0]     credits_q, credits_d;
  logic                  rd_pending_q, rd_pending_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CRED_W-1:0]     count_q, count_d;
  logic [DATA_WIDTH-1:0] fifo_q [RESP_DEPTH];

  logic fire, rd_fire, push, pop;

  // Ready is a function of registered state only, so a consumer may wait for
  // ready before raising valid without creating a combinational loop.
  assign req_ready = resetN && (credits_q != '0);
  assign fire      = req_valid && req_ready;
  assign rd_fire   = fire && !req_write;

  assign mem_enable = fire;
  assign mem_write  = req_write;
  assign mem_addr   = req_addr;
  assign mem_mask   = req_mask;
  assign mem_dataIn = req_dataIn;

  assign resp_valid   = resetN && (count_q != '0);
  assign resp_dataOut = fifo_q[rd_ptr_q];

  // SRAM read latency is one cycle, so the read issued last cycle has its
  // data on mem_dataOut now.
  assign push = rd_pending_q;
  assign pop  = resp_valid && resp_ready;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: every always_comb output gets a default first so no path can
  // infer a latch.
  always_comb begin
    credits_d    = credits_q;
    rd_pending_d = rd_fire;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;

    if (rd_fire && !pop)      credits_d = credits_q - CRED_W'(1);
    else if (pop && !rd_fire) credits_d = credits_q + CRED_W'(1);

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({push, pop})
      2'b10:   count_d = count_q + CRED_W'(1);
      2'b01:   count_d = count_q - CRED_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      credits_q    <= CRED_W'(RESP_DEPTH);
      rd_pending_q <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      credits_q    <= credits_d;
      rd_pending_q <= rd_pending_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // NOTE: FIFO storage is not reset; count_q alone decides which entries are
  // visible, so stale contents can never be observed.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= mem_dataOut;
  end

  a_param_legal: assert property (@(posedge clock)
    (ADDR_WIDTH == $clog2(DEPTH)) && ((DATA_WIDTH % MASK_UNIT) == 0) &&
    (RESP_DEPTH >= 2) && (RESP_DEPTH <= 16));

  a_credit_invariant: assert property (@(posedge clock) disable iff (!resetN)
    (32'(credits_q) + 32'(rd_pending_q) + 32'(count_q)) == RESP_DEPTH);

  a_no_overflow: assert property (@(posedge clock) disable iff (!resetN)
    !(push && (count_q == CRED_W'(RESP_DEPTH))));

endmodule

// File: tb/tb_sram_port_initiator.sv
// Directed testbench for sram_port_initiator with a behavioural masked SRAM
// (1-cycle read latency) attached to the mem_* port.
module tb_sram_port_initiator;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [MW-1:0] req_mask = '0;
  logic [DW-1:0] req_dataIn = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_dataOut;
  logic          mem_enable;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_mask;
  logic [DW-1:0] mem_dataIn;
  logic [DW-1:0] mem_dataOut;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  sram_port_initiator #(
    .DEPTH(1024), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_UNIT(8), .RESP_DEPTH(4)
  ) dut (
    .clock(clock), .resetN(resetN),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_mask(req_mask), .req_dataIn(req_dataIn),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_dataOut(resp_dataOut),
    .mem_enable(mem_enable), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_mask(mem_mask), .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  // Behavioural SRAM: masked byte writes, registered read data.
  logic [DW-1:0] sram [1024];
  always @(posedge clock) begin
    if (mem_enable) begin
      if (mem_write) begin
        for (int b = 0; b < MW; b++)
          if (mem_mask[b]) sram[mem_addr][b*8 +: 8] <= mem_dataIn[b*8 +: 8];
      end else begin
        mem_dataOut <= sram[mem_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [MW-1:0] m);
    req_valid  = v;
    req_write  = w;
    req_addr   = a;
    req_dataIn = d;
    req_mask   = m;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    drive(1'b1, 1'b1, a, d, m);
    tick();
    idle();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 10'h005, '0, '0);
    tick();
    tick();
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
    total++; if (mem_enable !== 1'b0) begin bad++; $display("FAIL rst_mem_enable got=%b exp=0", mem_enable); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    idle();
    resetN = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_req_ready got=%b exp=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL post_rst_resp_valid got=%b exp=0", resp_valid); end
    tick();
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
    #1;
    total++; if (mem_enable !== 1'b1 || mem_write !== 1'b1) begin bad++; $display("FAIL wr_enable got=%b/%b exp=1/1", mem_enable, mem_write); end
    total++; if (mem_addr !== 10'h010 || mem_mask !== 4'hF) begin bad++; $display("FAIL wr_addr_mask got=%h/%h exp=010/f", mem_addr, mem_mask); end
    total++; if (mem_dataIn !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_data got=%h exp=deadbeef", mem_dataIn); end
    tick();
    drive(1'b1, 1'b0, 10'h010, '0, '0);
    #1;
    total++; if (mem_enable !== 1'b1 || mem_write !== 1'b0) begin bad++; $display("FAIL rd_enable got=%b/%b exp=1/0", mem_enable, mem_write); end
    tick();
    idle();
    #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rd_latency_t1 got=%b exp=0", resp_valid); end
    tick();
    #1;
    total++; if (resp_valid !== 1'b1 || resp_dataOut !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_latency_t2 got=%b/%h exp=1/deadbeef", resp_valid, resp_dataOut); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rd_popped got=%b exp=0", resp_valid); end
  endtask

  task automatic test_masked();
    wr(10'h020, 32'h11223344, 4'hF);
    wr(10'h020, 32'hAABBCCDD, 4'h5);
    drive(1'b1, 1'b0, 10'h020, '0, '0);
    tick();
    idle();
    tick();
    #1;
    total++; if (resp_valid !== 1'b1 || resp_dataOut !== 32'h11BB33DD) begin bad++; $display("FAIL masked got=%b/%h exp=1/11bb33dd", resp_valid, resp_dataOut); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int acc;
    for (int i = 0; i < 6; i++) wr(10'(32'h100 + i), 32'hB000_0000 + 32'(i), 4'hF);
    resp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 10'(32'h100 + acc), '0, '0);
      #1;
      total++; if (req_ready !== (c < 4)) begin bad++; $display("FAIL bp_ready c=%0d got=%b exp=%b", c, req_ready, (c < 4)); end
      if (req_ready) acc++;
      tick();
    end
    idle();
    total++; if (acc != 4) begin bad++; $display("FAIL bp_accepted got=%0d exp=4", acc); end
    tick();
    #1;
    total++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b/%b exp=1/0", resp_valid, req_ready); end
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (resp_valid !== 1'b1 || resp_dataOut !== 32'hB000_0000 + 32'(k)) begin bad++; $display("FAIL bp_order k=%0d got=%b/%h exp=1/%h", k, resp_valid, resp_dataOut, 32'hB000_0000 + 32'(k)); end
      if (k == 0) begin
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_pop0 got=%b exp=0", req_ready); end
      end
      if (k == 1) begin
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_reassert got=%b exp=1", req_ready); end
      end
      tick();
    end
    #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b exp=0", resp_valid); end
    resp_ready = 1'b0;
  endtask

  task automatic test_streaming();
    int issued;
    int got;
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 1'b1, 10'(i), 32'h5A00_0000 | 32'(i), 4'hF);
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL stream_wr_ready i=%0d got=%b exp=1", i, req_ready); end
      tick();
    end
    idle();
    resp_ready = 1'b1;
    issued = 0;
    got = 0;
    for (int cyc = 0; cyc < 200 && got < 64; cyc++) begin
      if (issued < 64) drive(1'b1, 1'b0, 10'(issued), '0, '0);
      else idle();
      #1;
      if (issued < 64) begin
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL stream_rd_ready cyc=%0d got=%b exp=1", cyc, req_ready); end
      end
      if (resp_valid) begin
        total++; if (resp_dataOut !== (32'h5A00_0000 | 32'(got))) begin bad++; $display("FAIL stream_data n=%0d got=%h exp=%h", got, resp_dataOut, 32'h5A00_0000 | 32'(got)); end
        got++;
      end
      if (req_valid && req_ready) issued++;
      tick();
    end
    idle();
    total++; if (got != 64) begin bad++; $display("FAIL stream_count got=%0d exp=64", got); end
    #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL stream_drained got=%b exp=0", resp_valid); end
    resp_ready = 1'b0;
  endtask

  task automatic test_mixed();
    logic [DW-1:0] v [8];
    int s;
    int got;
    for (int k = 0; k < 8; k++) v[k] = 32'hC0DE_0000 + 32'(k) * 32'h111;
    s = 0;
    got = 0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      resp_ready = ((cyc % 3) != 0);
      if (s < 16) drive(1'b1, (s % 2) == 0, 10'h030, v[s/2], 4'hF);
      else idle();
      #1;
      if (resp_valid && resp_ready) begin
        total++; if (resp_dataOut !== v[got]) begin bad++; $display("FAIL mixed_data n=%0d got=%h exp=%h", got, resp_dataOut, v[got]); end
        got++;
      end
      if (req_valid && req_ready) s++;
      tick();
    end
    idle();
    resp_ready = 1'b0;
    total++; if (got != 8) begin bad++; $display("FAIL mixed_count got=%0d exp=8", got); end
  endtask

  task automatic test_reset_mid();
    int acc;
    wr(10'h200, 32'h600D_F00D, 4'hF);
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 10'(32'h100 + i), '0, '0);
      tick();
    end
    // Two entries queued, one read in flight.
    drive(1'b1, 1'b0, 10'h000, '0, '0);
    resetN = 1'b0;
    #1;
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin bad++; $display("FAIL midrst_outputs got=%b/%b exp=0/0", resp_valid, req_ready); end
    total++; if (mem_enable !== 1'b0) begin bad++; $display("FAIL midrst_mem_enable got=%b exp=0", mem_enable); end
    tick();
    resetN = 1'b1;
    idle();
    #1;
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL midrst_after got=%b/%b exp=1/0", req_ready, resp_valid); end
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL midrst_stale c=%0d got=%b exp=0", c, resp_valid); end
    end
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b0, 10'h200, '0, '0);
      #1;
      total++; if (req_ready !== (c < 4)) begin bad++; $display("FAIL midrst_credit c=%0d got=%b exp=%b", c, req_ready, (c < 4)); end
      if (req_ready) acc++;
      tick();
    end
    idle();
    total++; if (acc != 4) begin bad++; $display("FAIL midrst_accepted got=%0d exp=4", acc); end
    tick();
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (resp_valid !== 1'b1 || resp_dataOut !== 32'h600D_F00D) begin bad++; $display("FAIL midrst_data k=%0d got=%b/%h exp=1/600df00d", k, resp_valid, resp_dataOut); end
      tick();
    end
    #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL midrst_drained got=%b exp=0", resp_valid); end
    resp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_masked();
    test_backpressure();
    test_streaming();
    test_mixed();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
